// File: rtl/vh_sig_harness.sv
`default_nettype none
// ============================================================================
// Module   : vh_sig_harness
// Purpose  : LFSR stimulus source and 32-bit MISR response compactor wrapped
//            around one combinational expression module.
// Options  : VH_EXHAUSTIVE_EN - walk every a/b combination with an up-counter
//            instead of the LFSR (NUM_VECTORS and SEED unused).
// Revision : 1.0 - initial release
// ============================================================================
module vh_sig_harness #(
   parameter int unsigned A_WIDTH     = 4,
   parameter int unsigned B_WIDTH     = 4,
   parameter int unsigned Y_WIDTH     = 10,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [31:0] SEED        = 32'h0000_0001
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [A_WIDTH-1:0] dut_a,
   output logic [B_WIDTH-1:0] dut_b,
   input  logic [Y_WIDTH-1:0] dut_y,
   output logic               busy,
   output logic               done,
   output logic [31:0]        signature,
   output logic [31:0]        vec_count
);

   localparam int unsigned c_v_width = A_WIDTH + B_WIDTH;
   localparam logic [31:0] c_poly    = 32'h0040_0007;

`ifdef VH_EXHAUSTIVE_EN
   localparam int unsigned          c_s_width = c_v_width;
   localparam logic [31:0]          c_num     = 32'(64'd1 << c_v_width);
   localparam logic [c_s_width-1:0] c_first   = '0;
`else
   localparam int unsigned          c_s_width = 32;
   localparam logic [31:0]          c_num     = 32'(NUM_VECTORS);
   localparam logic [c_s_width-1:0] c_first   = (SEED == 32'h0) ? 32'h1 : SEED;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [c_s_width-1:0]   src_q, src_d;
   logic [31:0]            sig_q, sig_d;
   logic [31:0]            cnt_q, cnt_d;
   logic [c_s_width-1:0]   w_src_next;
   logic [31:0]            w_misr_next;

`ifdef VH_EXHAUSTIVE_EN
   assign w_src_next = src_q + c_s_width'(1);
`else
   assign w_src_next = {src_q[30:0], 1'b0} ^ (src_q[31] ? c_poly : 32'h0);
`endif

   // Response is zero-extended regardless of how the DUT interprets it.
   assign w_misr_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? c_poly : 32'h0)
                      ^ 32'(dut_y);

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               src_d   = c_first;
               sig_d   = 32'h0;
               cnt_d   = 32'h0;
            end
         end
         ST_RUN: begin
            sig_d = w_misr_next;
            cnt_d = cnt_q + 32'd1;
            // The last vector stays on dut_a/dut_b through DONE.
            if (cnt_q == c_num - 32'd1) begin
               state_d = ST_DONE;
            end else begin
               src_d = w_src_next;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         sig_q   <= 32'h0;
         cnt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dut_a     = src_q[c_v_width-1:B_WIDTH];
   assign dut_b     = src_q[B_WIDTH-1:0];
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign signature = sig_q;
   assign vec_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vh_sig_harness.sv
`default_nettype none
// ============================================================================
// Module   : tb_vh_sig_harness
// Purpose  : Directed, table-driven bench for vh_sig_harness (LFSR build, or
//            counter build when VH_EXHAUSTIVE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vh_sig_harness;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_m = 1'b0;
   logic        start_s = 1'b0;
   logic        ymode = 1'b0;

   logic [3:0]  a_m, b_m;
   logic [9:0]  y_m;
   logic        busy_m, done_m;
   logic [31:0] sig_m, cnt_m;

   logic [1:0]  a_s, b_s;
   logic [9:0]  y_s;
   logic        busy_s, done_s;
   logic [31:0] sig_s, cnt_s;

   logic [9:0]  pat [0:3];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign y_m = ymode ? ({2'b00, a_m, b_m} ^ 10'h2A5) : 10'h000;
`ifdef VH_EXHAUSTIVE_EN
   assign y_s = {8'h00, a_s ^ b_s};
`else
   assign y_s = (cnt_s < 32'd4) ? pat[cnt_s[1:0]] : 10'h000;
`endif

   vh_sig_harness #(
      .A_WIDTH(4), .B_WIDTH(4), .Y_WIDTH(10), .NUM_VECTORS(256), .SEED(32'h1)
   ) u_main (
      .clk(clk), .rst_n(rst_n), .start(start_m),
      .dut_a(a_m), .dut_b(b_m), .dut_y(y_m),
      .busy(busy_m), .done(done_m), .signature(sig_m), .vec_count(cnt_m)
   );

   vh_sig_harness #(
      .A_WIDTH(2), .B_WIDTH(2), .Y_WIDTH(10), .NUM_VECTORS(4), .SEED(32'h1)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .start(start_s),
      .dut_a(a_s), .dut_b(b_s), .dut_y(y_s),
      .busy(busy_s), .done(done_s), .signature(sig_s), .vec_count(cnt_s)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
   } ab_t;

   typedef struct {
      logic [9:0]  y0, y1, y2, y3;
      logic [31:0] sig;
   } sigvec_t;

   ab_t     stim_tab [0:4];
   sigvec_t sig_tab  [0:6];

   function automatic logic [31:0] step32(input logic [31:0] x);
      return {x[30:0], 1'b0} ^ (x[31] ? 32'h0040_0007 : 32'h0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic pulse(input bit sel);
      @(negedge clk);
      if (sel) start_s = 1'b1; else start_m = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      start_m = 1'b0;
   endtask

   task automatic wait_done(input bit sel, inout int n);
      while (!(sel ? done_s : done_m) && n < 2000) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] m, v, exp_main;
      int n;

`ifdef VH_EXHAUSTIVE_EN
      stim_tab[0] = '{4'h0, 4'h0};
      stim_tab[1] = '{4'h0, 4'h1};
      stim_tab[2] = '{4'h0, 4'h2};
      stim_tab[3] = '{4'h0, 4'h3};
      stim_tab[4] = '{4'h0, 4'h4};
`else
      stim_tab[0] = '{4'h0, 4'h1};
      stim_tab[1] = '{4'h0, 4'h2};
      stim_tab[2] = '{4'h0, 4'h4};
      stim_tab[3] = '{4'h0, 4'h8};
      stim_tab[4] = '{4'h1, 4'h0};
`endif
      // Four absorptions from zero never reach bit 31: sig = y0<<3^y1<<2^y2<<1^y3.
      sig_tab[0] = '{10'h001, 10'h000, 10'h000, 10'h000, 32'h0000_0008};
      sig_tab[1] = '{10'h000, 10'h000, 10'h000, 10'h001, 32'h0000_0001};
      sig_tab[2] = '{10'h3FF, 10'h000, 10'h000, 10'h000, 32'h0000_1FF8};
      sig_tab[3] = '{10'h001, 10'h001, 10'h001, 10'h001, 32'h0000_000F};
      sig_tab[4] = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 32'h0000_1004};
      sig_tab[5] = '{10'h155, 10'h2AA, 10'h000, 10'h000, 32'h0000_0000};
      sig_tab[6] = '{10'h200, 10'h200, 10'h200, 10'h200, 32'h0000_1E00};
      for (int i = 0; i < 4; i++) pat[i] = 10'h000;

      // Reference signature for the main instance with ymode=1.
      m = 32'h0;
`ifdef VH_EXHAUSTIVE_EN
      v = 32'h0;
`else
      v = 32'h1;
`endif
      for (int i = 0; i < 256; i++) begin
         m = step32(m) ^ {22'h0, {2'b00, v[7:0]} ^ 10'h2A5};
`ifdef VH_EXHAUSTIVE_EN
         v = v + 32'd1;
`else
         v = step32(v);
`endif
      end
      exp_main = m;

      repeat (3) @(negedge clk);
      chk("reset busy", {31'h0, busy_m}, 32'h0);
      chk("reset done", {31'h0, done_m}, 32'h0);
      chk("reset sig", sig_m, 32'h0);
      chk("reset cnt", cnt_m, 32'h0);
      chk("reset ab", {24'h0, a_m, b_m}, 32'h0);
      rst_n = 1'b1;

      // Zero response plus first five stimulus vectors.
      ymode = 1'b0;
      pulse(1'b0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stim a[%0d]", i), {28'h0, a_m}, {28'h0, stim_tab[i].a});
         chk($sformatf("stim b[%0d]", i), {28'h0, b_m}, {28'h0, stim_tab[i].b});
         @(negedge clk);
         n++;
      end
      wait_done(1'b0, n);
      chk("zero latency", n + 1, 257);
      chk("zero sig", sig_m, 32'h0);
      chk("zero cnt", cnt_m, 32'd256);
      chk("zero busy", {31'h0, busy_m}, 32'h0);

      // Start during RUN must be ignored.
      ymode = 1'b1;
      pulse(1'b0);
      n = 0;
      while (cnt_m != 32'd10 && n < 100) begin
         @(negedge clk);
         n++;
      end
      start_m = 1'b1;
      @(negedge clk);
      n++;
      start_m = 1'b0;
      wait_done(1'b0, n);
      chk("midstart latency", n + 1, 257);
      chk("midstart sig", sig_m, exp_main);
      chk("midstart cnt", cnt_m, 32'd256);

      // Restart from DONE clears and reproduces the signature.
      pulse(1'b0);
      chk("restart sig clr", sig_m, 32'h0);
      chk("restart cnt clr", cnt_m, 32'h0);
      chk("restart busy", {31'h0, busy_m}, 32'h1);
      chk("restart done", {31'h0, done_m}, 32'h0);
      n = 0;
      wait_done(1'b0, n);
      chk("restart sig", sig_m, exp_main);

      // Asynchronous reset in the middle of a run.
      pulse(1'b0);
      n = 0;
      while (cnt_m != 32'd5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("pre-reset busy", {31'h0, busy_m}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async busy", {31'h0, busy_m}, 32'h0);
      chk("async done", {31'h0, done_m}, 32'h0);
      chk("async sig", sig_m, 32'h0);
      chk("async cnt", cnt_m, 32'h0);
      chk("async ab", {24'h0, a_m, b_m}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef VH_EXHAUSTIVE_EN
      m = 32'h0;
      for (int i = 0; i < 16; i++) m = step32(m) ^ {30'h0, 2'(i >> 2) ^ 2'(i)};
      pulse(1'b1);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("exh ab[%0d]", i), {28'h0, a_s, b_s}, 32'(i));
         @(negedge clk);
         n++;
      end
      wait_done(1'b1, n);
      chk("exh latency", n + 1, 17);
      chk("exh cnt", cnt_s, 32'd16);
      chk("exh sig", sig_s, m);
      chk("exh last ab", {28'h0, a_s, b_s}, 32'hF);
`else
      for (int t = 0; t < 7; t++) begin
         pat[0] = sig_tab[t].y0;
         pat[1] = sig_tab[t].y1;
         pat[2] = sig_tab[t].y2;
         pat[3] = sig_tab[t].y3;
         pulse(1'b1);
         n = 0;
         wait_done(1'b1, n);
         chk($sformatf("small sig[%0d]", t), sig_s, sig_tab[t].sig);
         chk($sformatf("small cnt[%0d]", t), cnt_s, 32'd4);
         chk($sformatf("small lat[%0d]", t), n + 1, 5);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
